// File: rtl/segment_arbiter.sv
// Round-robin bus arbiter for one segment: single owner at a time, with release on done,
// request drop, decode miss or hold timeout, and a dead cycle between consecutive grants.
module segment_arbiter #(
   parameter int unsigned masters = 2,
   parameter int unsigned timeout = 256
) (
   input  logic                                            CLK,
   input  logic                                            RESET,
   input  logic [masters-1:0]                              BUS_REQUESTS,
   input  logic                                            BUS_DONE,
   input  logic                                            SELECT_ERROR,
   output logic [masters-1:0]                              BUS_GRANTS,
   output logic [((masters > 1) ? $clog2(masters) : 1)-1:0] GRANT_ID,
   output logic                                            BUS_BUSY,
   output logic                                            TIMEOUT_ABORT,
   output logic                                            DECODE_ABORT
);

   localparam int unsigned IdW  = (masters > 1) ? $clog2(masters) : 1;
   localparam int unsigned CntW = $clog2(timeout);

   typedef enum logic [0:0] {StIdle, StOwned} state_e;

   state_e             state_q, state_d;
   logic [masters-1:0] grants_q, grants_d;
   logic [IdW-1:0]     id_q, id_d;
   logic [IdW-1:0]     ptr_q, ptr_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               tabort_q, tabort_d;
   logic               dabort_q, dabort_d;

   logic               found;
   logic [IdW-1:0]     winner;
   logic [IdW-1:0]     idx;
   logic               expiry;
   logic               release_now;

   // First requester at or above the pointer, wrapping past masters-1.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < int'(masters); i++) begin
         idx = IdW'((int'(ptr_q) + i) % int'(masters));
         if (!found && BUS_REQUESTS[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign expiry      = (cnt_q == CntW'(timeout - 1));
   assign release_now = BUS_DONE | ~BUS_REQUESTS[id_q] | SELECT_ERROR | expiry;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= StIdle;
         grants_q <= '0;
         id_q     <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         tabort_q <= 1'b0;
         dabort_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grants_q <= grants_d;
         id_q     <= id_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         tabort_q <= tabort_d;
         dabort_q <= dabort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (found) state_d = StOwned;
         StOwned: if (release_now) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      grants_d = grants_q;
      id_d     = id_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      tabort_d = 1'b0;
      dabort_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grants_d         = '0;
               grants_d[winner] = 1'b1;
               id_d             = winner;
               busy_d           = 1'b1;
               cnt_d            = '0;
            end
         end
         StOwned: begin
            cnt_d = cnt_q + 1'b1;
            if (release_now) begin
               grants_d = '0;
               id_d     = '0;
               busy_d   = 1'b0;
               cnt_d    = '0;
               ptr_d    = IdW'((int'(id_q) + 1) % int'(masters));
               // Done wins over both aborts; decode miss wins over timeout.
               dabort_d = SELECT_ERROR & ~BUS_DONE;
               tabort_d = expiry & ~BUS_DONE & ~SELECT_ERROR;
            end
         end
         default: ;
      endcase
   end

   assign BUS_GRANTS    = grants_q;
   assign GRANT_ID      = id_q;
   assign BUS_BUSY      = busy_q;
   assign TIMEOUT_ABORT = tabort_q;
   assign DECODE_ABORT  = dabort_q;

endmodule

// File: doc/segment_arbiter.md
SEGMENT_ARBITER -- requirements
Module: segment_arbiter

Interface
REQ-001 SHALL have parameter: masters, 2, number of requesting bus masters (1..32).
REQ-002 SHALL have parameter: timeout, 256, maximum cycles one grant may be held (2..65536).
REQ-003 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: BUS_REQUESTS  input  [masters-1:0]  per-master bus request, level-held.
REQ-006 SHALL have port: BUS_DONE  input  1  owning master's transaction complete, one-cycle pulse.
REQ-007 SHALL have port: SELECT_ERROR  input  1  address decode miss from the segment decoder.
REQ-008 SHALL have port: BUS_GRANTS  output  [masters-1:0]  one-hot or zero grant vector, feeds decoder and muxes.
REQ-009 SHALL have port: GRANT_ID  output  [$clog2(masters)-1:0] (min 1 bit)  index of current owner; 0 when idle.
REQ-010 SHALL have port: BUS_BUSY  output  1  high while any grant is active.
REQ-011 SHALL have port: TIMEOUT_ABORT  output  1  one-cycle pulse when a grant is revoked by timeout.
REQ-012 SHALL have port: DECODE_ABORT  output  1  one-cycle pulse when a grant is revoked by SELECT_ERROR.

Function
REQ-013 SHALL implement two states: IDLE (no grant) and OWNED (exactly one grant bit set).
REQ-014 SHALL, in IDLE with any BUS_REQUESTS bit set at edge n, enter OWNED and assert the winner's BUS_GRANTS bit from edge n (visible cycle n+1); one-cycle request-to-grant latency.
REQ-015 SHALL select the winner round-robin: first requesting index at or above pointer, wrapping from masters-1 to 0.
REQ-016 SHALL reset the pointer to 0 and, on each release, set it to (owner+1) mod masters.
REQ-017 SHALL hold BUS_GRANTS, GRANT_ID, BUS_BUSY constant throughout OWNED; no preemption.
REQ-018 SHALL release (return to IDLE, grant zero next cycle) on any of: BUS_DONE high, owner's request bit low, SELECT_ERROR high, or timeout expiry.
REQ-019 SHALL spend at least one IDLE cycle between consecutive grants (dead cycle for bus turnaround), even when requests are pending.
REQ-020 SHALL count cycles in OWNED with a counter cleared on entry; expiry is count == timeout-1 in OWNED.
REQ-021 SHALL, when BUS_DONE and expiry coincide, treat the release as normal: no TIMEOUT_ABORT.
REQ-022 SHALL pulse DECODE_ABORT the cycle after SELECT_ERROR is sampled high in OWNED, unless BUS_DONE is high the same cycle; SELECT_ERROR is ignored in IDLE.
REQ-023 SHALL pulse TIMEOUT_ABORT the cycle after expiry, unless SELECT_ERROR was also high (DECODE_ABORT takes priority; never both pulses).
REQ-024 SHALL ignore BUS_DONE in IDLE.
REQ-025 SHALL keep all outputs registered; no combinational path from inputs to outputs.
REQ-026 SHALL tie BUS_GRANTS[0] to BUS_REQUESTS[0] behaviour unchanged when masters==1 (same FSM, pointer fixed at 0).

Reset
REQ-027 SHALL, while RESET is high, force state IDLE, BUS_GRANTS=0, GRANT_ID=0, BUS_BUSY=0, TIMEOUT_ABORT=0, DECODE_ABORT=0, pointer=0, counter=0, independent of CLK.
REQ-028 SHALL, on RESET asserted mid-OWNED, drop the grant immediately and emit no abort pulse.
REQ-029 SHALL begin arbitration on the first rising edge after RESET deasserts.

Verification (masters=2, timeout=16)
REQ-030 SHALL cover: BUS_REQUESTS=2'b11 held from reset release, BUS_DONE every 4th grant cycle -> grants alternate 01,10,01 with one zero cycle between each.
REQ-031 SHALL cover: BUS_REQUESTS=2'b01 at cycle 0 -> BUS_GRANTS=01, GRANT_ID=0, BUS_BUSY=1 at cycle 1; BUS_DONE at cycle 3 -> BUS_GRANTS=00 at cycle 4.
REQ-032 SHALL cover: grant held with no BUS_DONE -> TIMEOUT_ABORT pulses exactly once, 16 cycles after grant, grant zero same cycle.
REQ-033 SHALL cover: SELECT_ERROR high 2 cycles into grant -> DECODE_ABORT one pulse next cycle, grant dropped, pointer advanced.
REQ-034 SHALL cover: BUS_DONE coincident with expiry -> release, TIMEOUT_ABORT stays 0.
REQ-035 SHALL cover: RESET asserted asynchronously mid-grant -> BUS_GRANTS=00 before next CLK edge, no abort pulses, next grant goes to master 0.
